// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: two-entry skid-buffered register with flush, bubble gating and a forwarding tap.
// Optional performance counters are enabled with the macro EX_MEM_PERF_CNT_EN; otherwise they are tied to 0.
module ex_mem_stage #(
    parameter int N  = 32,
    parameter int RA = 5,
    parameter int CW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          valid_ex,
    output logic          ready_ex,
    input  logic          wr_en_ex,
    input  logic          wd_sel_ex,
    input  logic          wm_en_ex,
    input  logic [RA-1:0] rw_ex,
    input  logic [N-1:0]  alu_result_ex,
    input  logic [N-1:0]  rdb_ex,
    output logic          valid_mem,
    input  logic          ready_mem,
    output logic          wr_en_mem,
    output logic          wd_sel_mem,
    output logic          wm_en_mem,
    output logic [RA-1:0] rw_mem,
    output logic [N-1:0]  alu_result_mem,
    output logic [N-1:0]  rdb_mem,
    output logic          fwd_valid,
    output logic [RA-1:0] fwd_rw,
    output logic [N-1:0]  fwd_data,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    // Payload layout: {wr_en, wd_sel, wm_en, rw, alu_result, rdb}
    localparam int PW = 3 + RA + 2 * N;

    logic          out_valid;
    logic          skid_valid;
    logic [PW-1:0] out_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_beat;
    logic          in_fire;
    logic          out_free;
    logic          out_wr_en;
    logic          out_wm_en;

    // Handshake: a beat moves on a rising edge when valid and ready are both high
    // on that side; valid never depends on ready, and ready_ex is a pure flop
    // output (empty skid), so no combinational path runs from ready_mem to ready_ex.
    assign in_beat  = {wr_en_ex, wd_sel_ex, wm_en_ex, rw_ex, alu_result_ex, rdb_ex};
    assign ready_ex = !skid_valid;
    assign in_fire  = valid_ex & ready_ex;
    assign out_free = !out_valid | ready_mem;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Payload registers keep stale data; only the valid bits matter.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_q <= in_beat;
                end
            end else if (in_fire) begin
                out_q     <= in_beat;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign {out_wr_en, wd_sel_mem, out_wm_en, rw_mem, alu_result_mem, rdb_mem} = out_q;

    // Bubble gating keeps an empty slot from ever writing the register file or memory.
    assign valid_mem = out_valid;
    assign wr_en_mem = out_wr_en & out_valid;
    assign wm_en_mem = out_wm_en & out_valid;

    assign fwd_valid = valid_mem & wr_en_mem & (rw_mem != '0);
    assign fwd_rw    = rw_mem;
    assign fwd_data  = alu_result_mem;

`ifdef EX_MEM_PERF_CNT_EN
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Saturating counters; flush does not touch them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !ready_mem && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (!out_valid && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic against a
// queue-based model (the stage is a lossless FIFO of depth 2, ready_ex meaning "fewer than 2 held").
module tb_ex_mem_stage;

    localparam int N  = 32;
    localparam int RA = 5;
    localparam int CW = 4;
    localparam int BW = 3 + RA + 2 * N;
    localparam int CTW = 5 + 2 * CW;
    localparam int DTW = 1 + 2 * RA + 3 * N;
`ifdef EX_MEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic          wr_en;
        logic          wd_sel;
        logic          wm_en;
        logic [RA-1:0] rw;
        logic [N-1:0]  alu;
        logic [N-1:0]  rdb;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset, flush, valid_ex, ready_mem;
    logic          wr_en_ex, wd_sel_ex, wm_en_ex;
    logic [RA-1:0] rw_ex;
    logic [N-1:0]  alu_result_ex, rdb_ex;
    logic          ready_ex, valid_mem, wr_en_mem, wd_sel_mem, wm_en_mem, fwd_valid;
    logic [RA-1:0] rw_mem, fwd_rw;
    logic [N-1:0]  alu_result_mem, rdb_mem, fwd_data;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    logic [BW-1:0]  exp_q[$];
    logic [CW-1:0]  exp_stall, exp_bubble;
    int             check_count = 0;
    int             pass_count  = 0;

    logic [CTW-1:0] dut_ctrl;
    logic [DTW-1:0] dut_data;

    always #5 clock = ~clock;

    ex_mem_stage #(.N(N), .RA(RA), .CW(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .valid_ex(valid_ex), .ready_ex(ready_ex),
        .wr_en_ex(wr_en_ex), .wd_sel_ex(wd_sel_ex), .wm_en_ex(wm_en_ex),
        .rw_ex(rw_ex), .alu_result_ex(alu_result_ex), .rdb_ex(rdb_ex),
        .valid_mem(valid_mem), .ready_mem(ready_mem),
        .wr_en_mem(wr_en_mem), .wd_sel_mem(wd_sel_mem), .wm_en_mem(wm_en_mem),
        .rw_mem(rw_mem), .alu_result_mem(alu_result_mem), .rdb_mem(rdb_mem),
        .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    assign dut_ctrl = {valid_mem, ready_ex, wr_en_mem, wm_en_mem, fwd_valid, stall_cnt, bubble_cnt};
    assign dut_data = {wd_sel_mem, rw_mem, alu_result_mem, rdb_mem, fwd_rw, fwd_data};

    // ---------------- reference model ----------------
    function automatic logic [CTW-1:0] exp_ctrl();
        beat_t f;
        logic  v;
        v = (exp_q.size() > 0);
        f = v ? beat_t'(exp_q[0]) : beat_t'('0);
        return {v, (exp_q.size() < 2), f.wr_en & v, f.wm_en & v,
                v & f.wr_en & (f.rw != '0), exp_stall, exp_bubble};
    endfunction

    function automatic logic [DTW-1:0] exp_data();
        beat_t f;
        f = beat_t'(exp_q[0]);
        return {f.wd_sel, f.rw, f.alu, f.rdb, f.rw, f.alu};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.wr_en  = 1'($urandom_range(0, 1));
        b.wd_sel = 1'($urandom_range(0, 1));
        b.wm_en  = 1'($urandom_range(0, 1));
        b.rw     = RA'($urandom_range(0, (1 << RA) - 1));
        b.alu    = $urandom;
        b.rdb    = $urandom;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input beat_t b);
        valid_ex = v;
        {wr_en_ex, wd_sel_ex, wm_en_ex, rw_ex, alu_result_ex, rdb_ex} = b;
    endtask

    // Advance one edge, updating the model from the inputs the DUT samples at that edge.
    task automatic tick();
        logic [BW-1:0] in_bus;
        logic          acc;
        in_bus = {wr_en_ex, wd_sel_ex, wm_en_ex, rw_ex, alu_result_ex, rdb_ex};
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            exp_stall  = '0;
            exp_bubble = '0;
        end else begin
            if (PERF) begin
                if (exp_q.size() > 0 && !ready_mem && exp_stall != '1) exp_stall = exp_stall + 1'b1;
                if (exp_q.size() == 0 && exp_bubble != '1) exp_bubble = exp_bubble + 1'b1;
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = valid_ex && (exp_q.size() < 2);
                if (exp_q.size() > 0 && ready_mem) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(in_bus);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; ready_mem = 1'b0;
        drive(1'b0, '0);
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ready_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rand_beat());
            tick();
            check_count++;
            if (dut_ctrl !== exp_ctrl() || dut_ctrl !== {5'b01000, {(2*CW){1'b0}}})
                $display("FAIL reset_ctrl: got %h exp %h", dut_ctrl, exp_ctrl());
            else pass_count++;
            check_count++;
            if (dut_data !== '0) $display("FAIL reset_data: got %h exp 0", dut_data);
            else pass_count++;
        end
        reset = 1'b0;
        drive(1'b0, '0);
    endtask

    task automatic test_streaming();
        beat_t b;
        logic [N-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        do_reset();
        ready_mem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = rand_beat();
            if (i < 3) begin
                b.alu = vals[i];
                drive(1'b1, b);
            end else drive(1'b0, b);
            tick();
            check_count++;
            if (dut_ctrl !== exp_ctrl()) $display("FAIL stream_ctrl: got %h exp %h", dut_ctrl, exp_ctrl());
            else pass_count++;
            if (exp_q.size() > 0) begin
                check_count++;
                if (dut_data !== exp_data()) $display("FAIL stream_data: got %h exp %h", dut_data, exp_data());
                else pass_count++;
            end
            check_count++;
            if (i < 3 && !(valid_mem === 1'b1 && alu_result_mem === vals[i]))
                $display("FAIL stream_value: got v=%b %h exp v=1 %h", valid_mem, alu_result_mem, vals[i]);
            else if (i == 3 && valid_mem !== 1'b0)
                $display("FAIL stream_drain: got v=%b exp v=0", valid_mem);
            else pass_count++;
        end
    endtask

    task automatic test_backpressure();
        beat_t        b;
        int           idx;
        logic [N-1:0] got[$];
        do_reset();
        idx = 0;
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            ready_mem = !(c >= 1 && c <= 3);
            b = rand_beat();
            b.alu = 32'hA0 + N'(idx);
            drive(idx < 5, b);
            if (valid_mem && ready_mem) got.push_back(alu_result_mem);
            if (valid_ex && ready_ex) idx++;
            tick();
            check_count++;
            if (dut_ctrl !== exp_ctrl()) $display("FAIL bp_ctrl: cycle %0d got %h exp %h", c, dut_ctrl, exp_ctrl());
            else pass_count++;
            if (exp_q.size() > 0) begin
                check_count++;
                if (dut_data !== exp_data()) $display("FAIL bp_data: got %h exp %h", dut_data, exp_data());
                else pass_count++;
            end
        end
        check_count++;
        if (got.size() != 5) $display("FAIL bp_count: got %0d beats exp 5", got.size());
        else pass_count++;
        for (int i = 0; i < got.size() && i < 5; i++) begin
            check_count++;
            if (got[i] !== 32'hA0 + N'(i)) $display("FAIL bp_order: slot %0d got %h exp %h", i, got[i], 32'hA0 + N'(i));
            else pass_count++;
        end
        check_count++;
        if (stall_cnt !== (PERF ? CW'(3) : CW'(0))) $display("FAIL bp_stall_cnt: got %0d exp %0d", stall_cnt, PERF ? 3 : 0);
        else pass_count++;
    endtask

    task automatic test_flush();
        beat_t b;
        logic  seen_ff;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            b = rand_beat();
            b.wr_en = 1'b1; b.wm_en = 1'b1; b.alu = 32'hC0 + N'(i);
            drive(1'b1, b);
            tick();
        end
        check_count++;
        if (dut_ctrl !== exp_ctrl() || ready_ex !== 1'b0) $display("FAIL flush_full: got %h exp %h", dut_ctrl, exp_ctrl());
        else pass_count++;
        b = rand_beat();
        b.wr_en = 1'b1; b.wm_en = 1'b1; b.alu = 32'hFF;
        drive(1'b1, b);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        check_count++;
        if ({valid_mem, wr_en_mem, wm_en_mem, ready_ex} !== 4'b0001)
            $display("FAIL flush_clear: got v/we/wm/rdy=%b%b%b%b exp 0001", valid_mem, wr_en_mem, wm_en_mem, ready_ex);
        else pass_count++;
        check_count++;
        if (dut_ctrl !== exp_ctrl()) $display("FAIL flush_ctrl: got %h exp %h", dut_ctrl, exp_ctrl());
        else pass_count++;
        ready_mem = 1'b1;
        seen_ff = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_mem && alu_result_mem == 32'hFF) seen_ff = 1'b1;
        end
        check_count++;
        if (seen_ff || dut_ctrl !== exp_ctrl()) $display("FAIL flush_ghost: seen_ff=%b got %h exp %h", seen_ff, dut_ctrl, exp_ctrl());
        else pass_count++;
    endtask

    task automatic test_forwarding();
        beat_t b;
        do_reset();
        ready_mem = 1'b1;
        b = rand_beat(); b.rw = '0; b.wr_en = 1'b1;
        drive(1'b1, b);
        tick();
        check_count++;
        if ({valid_mem, fwd_valid} !== 2'b10) $display("FAIL fwd_r0: got v/fwd=%b%b exp 10", valid_mem, fwd_valid);
        else pass_count++;
        b = rand_beat(); b.rw = RA'(7); b.wr_en = 1'b1; b.alu = 32'h1234;
        drive(1'b1, b);
        tick();
        check_count++;
        if ({fwd_valid, fwd_rw, fwd_data} !== {1'b1, RA'(7), 32'h1234})
            $display("FAIL fwd_r7: got %b %0d %h exp 1 7 1234", fwd_valid, fwd_rw, fwd_data);
        else pass_count++;
        b.wr_en = 1'b0;
        drive(1'b1, b);
        tick();
        drive(1'b0, '0);
        check_count++;
        if ({valid_mem, fwd_valid} !== 2'b10) $display("FAIL fwd_nowr: got v/fwd=%b%b exp 10", valid_mem, fwd_valid);
        else pass_count++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, rand_beat());
        tick();
        drive(1'b0, '0);
        for (int i = 0; i < 20; i++) tick();
        check_count++;
        if (stall_cnt !== (PERF ? CW'(15) : CW'(0))) $display("FAIL sat_stall: got %0d exp %0d", stall_cnt, PERF ? 15 : 0);
        else pass_count++;
        check_count++;
        if (dut_ctrl !== exp_ctrl()) $display("FAIL sat_ctrl: got %h exp %h", dut_ctrl, exp_ctrl());
        else pass_count++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ready_mem = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, rand_beat());
            tick();
            check_count++;
            if (dut_ctrl !== exp_ctrl()) begin
                if (errs < 10) $display("FAIL rand_ctrl: cycle %0d got %h exp %h", c, dut_ctrl, exp_ctrl());
                errs++;
            end else pass_count++;
            if (exp_q.size() > 0) begin
                check_count++;
                if (dut_data !== exp_data()) begin
                    if (errs < 10) $display("FAIL rand_data: cycle %0d got %h exp %h", c, dut_data, exp_data());
                    errs++;
                end else pass_count++;
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ready_mem = 1'b0;
        drive(1'b0, '0);
        exp_stall = '0; exp_bubble = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
